// File: rtl/frame_energy_acc.sv
// frame_energy_acc: three-stage sum-of-squares over fixed-length frames
// of signed audio samples, feeding a downstream log2 stage.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      async active-low reset
//   i_valid    sample qualifier (no backpressure)
//   i_data     signed sample, DATA_W bits
//   i_restart  abort partial frame (travels with its sample)
//   o_valid    one-cycle pulse, frame energy ready
//   o_energy   unsigned frame energy, held between pulses
//
// Build option: define ENERGY_FLOOR_EN to report a zero-energy frame as 1.
module frame_energy_acc #(
   parameter int DATA_W    = 16,
   parameter int FRAME_LEN = 256,
   parameter int O_WIDTH   = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_valid,
   input  logic [DATA_W-1:0]  i_data,
   input  logic               i_restart,
   output logic               o_valid,
   output logic [O_WIDTH-1:0] o_energy
);

   localparam int SQ_W  = 2 * DATA_W;
   localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

   // stage 1
   logic                     s1_valid_q, s1_valid_d;
   logic                     s1_restart_q, s1_restart_d;
   logic signed [DATA_W-1:0] s1_data_q, s1_data_d;

   // stage 2
   logic                     s2_valid_q, s2_valid_d;
   logic                     s2_restart_q, s2_restart_d;
   logic [SQ_W-1:0]          s2_sq_q, s2_sq_d;

   // stage 3
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [O_WIDTH-1:0]       acc_q, acc_d;
   logic                     o_valid_q, o_valid_d;
   logic [O_WIDTH-1:0]       o_energy_q, o_energy_d;

   logic signed [SQ_W-1:0]   s1_ext;
   logic signed [SQ_W-1:0]   sq_full;
   logic [O_WIDTH-1:0]       sq_ext;
   logic [O_WIDTH-1:0]       sum;
   logic [O_WIDTH-1:0]       frame_e;

   // Square at full 2*DATA_W signed width: (-2^(W-1))^2 = 2^(2W-2)
   // still fits as a positive value, so the reinterpretation is exact.
   always_comb begin
      s1_ext  = SQ_W'(s1_data_q);
      sq_full = s1_ext * s1_ext;
   end

   always_comb begin
      s1_valid_d   = i_valid;
      s1_restart_d = i_restart;
      s1_data_d    = i_data;
      s2_valid_d   = s1_valid_q;
      s2_restart_d = s1_restart_q;
      s2_sq_d      = $unsigned(sq_full);
   end

   always_comb begin
      sq_ext = O_WIDTH'(s2_sq_q);
      sum    = acc_q + sq_ext;
`ifdef ENERGY_FLOOR_EN
      frame_e = (sum == '0) ? O_WIDTH'(1) : sum;
`else
      frame_e = sum;
`endif
   end

   always_comb begin
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      o_valid_d  = 1'b0;
      o_energy_d = o_energy_q;
      if (s2_restart_q) begin
         // restart wins over completion: no pulse for the aborted frame
         if (s2_valid_q) begin
            acc_d = sq_ext;
            cnt_d = CNT_W'(1);
         end else begin
            acc_d = '0;
            cnt_d = '0;
         end
      end else if (s2_valid_q) begin
         if (cnt_q == LAST) begin
            cnt_d      = '0;
            acc_d      = sum;
            o_valid_d  = 1'b1;
            o_energy_d = frame_e;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = (cnt_q == '0) ? sq_ext : sum;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_restart_q <= 1'b0;
         s1_data_q    <= '0;
         s2_valid_q   <= 1'b0;
         s2_restart_q <= 1'b0;
         s2_sq_q      <= '0;
         cnt_q        <= '0;
         acc_q        <= '0;
         o_valid_q    <= 1'b0;
         o_energy_q   <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_restart_q <= s1_restart_d;
         s1_data_q    <= s1_data_d;
         s2_valid_q   <= s2_valid_d;
         s2_restart_q <= s2_restart_d;
         s2_sq_q      <= s2_sq_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         o_valid_q    <= o_valid_d;
         o_energy_q   <= o_energy_d;
      end
   end

   assign o_valid  = o_valid_q;
   assign o_energy = o_energy_q;

endmodule

// File: tb/tb_frame_energy_acc.sv
// tb_frame_energy_acc: directed vectors for frame_energy_acc,
// one instance with FRAME_LEN=4 and one with FRAME_LEN=256.
module tb_frame_energy_acc;

   logic        clk;
   logic        rst_n;
   logic        i_valid;
   logic [15:0] i_data;
   logic        i_restart;
   logic        o_valid4;
   logic [63:0] o_energy4;
   logic        o_valid256;
   logic [63:0] o_energy256;

`ifdef ENERGY_FLOOR_EN
   localparam logic [63:0] ZERO_E = 64'd1;
`else
   localparam logic [63:0] ZERO_E = 64'd0;
`endif

   frame_energy_acc #(.DATA_W(16), .FRAME_LEN(4), .O_WIDTH(64)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_valid   (i_valid),
      .i_data    (i_data),
      .i_restart (i_restart),
      .o_valid   (o_valid4),
      .o_energy  (o_energy4)
   );

   frame_energy_acc #(.DATA_W(16), .FRAME_LEN(256), .O_WIDTH(64)) dut256 (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_valid   (i_valid),
      .i_data    (i_data),
      .i_restart (i_restart),
      .o_valid   (o_valid256),
      .o_energy  (o_energy256)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_c = 0;
   int pc4 = 0;
   logic [63:0] q4[$];
   logic [63:0] q256[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (o_valid4) begin
         q4.push_back(o_energy4);
         pc4 = cyc;
      end
      if (o_valid256) q256.push_back(o_energy256);
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic send(input int d, input logic rs);
      @(negedge clk);
      i_valid   = 1'b1;
      i_data    = 16'(d);
      i_restart = rs;
      last_c    = cyc;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         i_valid   = 1'b0;
         i_data    = 16'($urandom);
         i_restart = 1'b0;
      end
   endtask

   task automatic pop4(input string tag, input logic [63:0] exp);
      logic [63:0] v;
      v = (q4.size() > 0) ? q4.pop_front() : 64'hdead_beef_dead_beef;
      chk(tag, v, exp);
   endtask

   task automatic pop256(input string tag, input logic [63:0] exp);
      logic [63:0] v;
      v = (q256.size() > 0) ? q256.pop_front() : 64'hdead_beef_dead_beef;
      chk(tag, v, exp);
   endtask

   initial begin
      rst_n     = 1'b0;
      i_valid   = 1'b0;
      i_data    = '0;
      i_restart = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 64'(o_valid4), 64'd0);
      chk("rst_energy", o_energy4, 64'd0);
      rst_n = 1'b1;
      idle(2);

      // four samples of 1000, latency and single pulse
      for (int k = 0; k < 4; k++) send(1000, 1'b0);
      idle(6);
      chk("lat", 64'(pc4 - last_c), 64'd3);
      chk("n_1000", 64'(q4.size()), 64'd1);
      pop4("e_1000", 64'd4000000);
      chk("hold", o_energy4, 64'd4000000);
      chk("pulse_low", 64'(o_valid4), 64'd0);

      // gaps with junk data while invalid
      send(3, 1'b0);
      idle(5);
      send(-4, 1'b0);
      idle(5);
      send(5, 1'b0);
      send(-6, 1'b0);
      idle(6);
      chk("n_gap", 64'(q4.size()), 64'd1);
      pop4("e_gap", 64'd86);

      // restart with a valid sample starts a new frame
      send(7, 1'b0);
      send(7, 1'b0);
      send(2, 1'b1);
      send(1, 1'b0);
      send(1, 1'b0);
      send(1, 1'b0);
      idle(6);
      chk("n_rst", 64'(q4.size()), 64'd1);
      pop4("e_rst", 64'd7);

      // restart on the would-be final sample suppresses the pulse
      send(1, 1'b0);
      send(1, 1'b0);
      send(1, 1'b0);
      send(5, 1'b1);
      idle(6);
      chk("n_sup", 64'(q4.size()), 64'd0);
      send(2, 1'b0);
      send(2, 1'b0);
      send(2, 1'b0);
      idle(6);
      chk("n_sup2", 64'(q4.size()), 64'd1);
      pop4("e_sup2", 64'd37);

      // restart without valid clears, then an all-zero frame
      send(3, 1'b0);
      send(3, 1'b0);
      @(negedge clk);
      i_valid   = 1'b0;
      i_restart = 1'b1;
      for (int k = 0; k < 4; k++) send(0, 1'b0);
      idle(6);
      chk("n_zero", 64'(q4.size()), 64'd1);
      pop4("e_zero", ZERO_E);

      // back-to-back frames
      for (int k = 1; k <= 8; k++) send(k, 1'b0);
      idle(6);
      chk("n_b2b", 64'(q4.size()), 64'd2);
      pop4("e_b2b0", 64'd30);
      pop4("e_b2b1", 64'd174);

      // reset mid-frame, sample accepted in release cycle
      send(100, 1'b0);
      send(100, 1'b0);
      @(negedge clk);
      i_valid = 1'b0;
      rst_n   = 1'b0;
      #1;
      chk("arst_valid", 64'(o_valid4), 64'd0);
      chk("arst_energy", o_energy4, 64'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      i_valid   = 1'b1;
      i_data    = 16'd10;
      i_restart = 1'b0;
      for (int k = 0; k < 3; k++) send(10, 1'b0);
      idle(6);
      chk("n_arst", 64'(q4.size()), 64'd1);
      pop4("e_arst", 64'd400);

      // full-length frames at the sample extremes
      @(negedge clk);
      i_valid   = 1'b0;
      i_restart = 1'b1;
      q256.delete();
      for (int k = 0; k < 256; k++) send(-32768, 1'b0);
      for (int k = 0; k < 256; k++) send(32767, 1'b0);
      idle(6);
      pop4("e_min4", 64'd4294967296);
      chk("n_256", 64'(q256.size()), 64'd2);
      pop256("e_min", 64'd274877906944);
      pop256("e_max", 64'd274861129984);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/frame_energy_acc.md
FRAME_ENERGY_ACC -- requirements
Module: frame_energy_acc

Interface
REQ-001 Parameter DATA_W, default 16, signed input sample width.
REQ-002 Parameter FRAME_LEN, default 256, samples per frame; legal range 2..65536.
REQ-003 Parameter O_WIDTH, default 64, energy output width; SHALL satisfy O_WIDTH >= 2*DATA_W + clog2(FRAME_LEN), no overflow handling needed.
REQ-004 clk  input  1  sole clock, all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_valid  input  1  qualifies i_data for one cycle; no backpressure, gaps allowed.
REQ-007 i_data  input  DATA_W  signed two's-complement audio sample.
REQ-008 i_restart  input  1  synchronous abort of the partial frame.
REQ-009 o_valid  output  1  one-cycle pulse, frame energy ready.
REQ-010 o_energy  output  O_WIDTH  unsigned sum of squares of the last completed frame; zero-extended feed for the downstream log2 stage.

Function
REQ-011 Pipeline: stage 1 registers i_data, i_valid, i_restart; stage 2 registers square s1_data*s1_data as unsigned 2*DATA_W bits; stage 3 accumulates.
REQ-012 Square of the most negative sample (-2^(DATA_W-1)) SHALL equal 2^(2*DATA_W-2) exactly, no sign error.
REQ-013 Sample counter cnt, range 0..FRAME_LEN-1, advances only on stage-2 valid.
REQ-014 On stage-2 valid with cnt==0: acc <= square; otherwise acc <= acc + square.
REQ-015 On stage-2 valid with cnt==FRAME_LEN-1: o_energy <= acc + square, o_valid <= 1, cnt <= 0.
REQ-016 Latency: last sample of a frame presented at edge T -> o_valid high in the cycle after edge T+3 (3-cycle latency), exactly one cycle wide.
REQ-017 o_energy SHALL hold its value between pulses; it changes only with o_valid.
REQ-018 Invalid cycles SHALL not alter cnt, acc or outputs, regardless of i_data.
REQ-019 i_restart travels the pipeline alongside its sample; at stage 3 it forces cnt and acc to discard the partial frame, no o_valid for it.
REQ-020 i_restart with i_valid in the same cycle: that sample becomes sample 0 of the new frame (acc <= square, cnt <= 1).
REQ-021 i_restart without i_valid: cnt <= 0, acc <= 0.
REQ-022 i_restart arriving on the would-be final sample SHALL suppress o_valid for that frame.
REQ-023 Frames are back-to-back: the sample following the final one is sample 0 of the next frame, no dead cycle.

Reset
REQ-024 rst_n low asynchronously clears all pipeline registers, cnt, acc, o_valid=0, o_energy=0.
REQ-025 Reset mid-frame discards the partial frame; first valid sample after release is sample 0.
REQ-026 Samples presented in the cycle of reset deassertion are accepted normally.

Configuration
REQ-027 Macro ENERGY_FLOOR_EN defined: a completed frame energy of 0 SHALL be output as 1, so the downstream log2 sees a defined minimum (result 0).
REQ-028 Macro ENERGY_FLOOR_EN undefined: o_energy is the raw sum, 0 passed through unchanged; latency identical in both builds.

Verification
REQ-029 FRAME_LEN=4, four consecutive samples 1000 -> one o_valid pulse, o_energy=4000000, 3 cycles after the 4th sample.
REQ-030 FRAME_LEN=256, 256 samples of -32768 -> o_energy=2^38 (274877906944); then 256 samples of +32767 -> o_energy=274861129984.
REQ-031 FRAME_LEN=4, samples 3,-4 with 5 idle cycles each between, then 5,-6 -> o_energy=86, single pulse.
REQ-032 FRAME_LEN=4, samples 7,7, then 2 with i_restart, then 1,1,1 -> no pulse for the aborted frame, one pulse with o_energy=7.
REQ-033 FRAME_LEN=4, four zero samples -> o_energy=1 with ENERGY_FLOOR_EN, 0 without.
REQ-034 rst_n pulsed low after 2 samples of 100 (FRAME_LEN=4) -> outputs 0 immediately; next 4 samples of 10 -> o_energy=400.
